tunnel_painter: RTL and testbench

Parametrised, fully pipelined pixel painter for the LED panel. It is the successor to the fixed 64×64 circle-tunnel painter. For every scanned pixel it computes a distance from a configurable centre using one of three metrics: exact Euclidean through a pipelined integer square root, diamond, or square. It then subtracts or adds a frame-driven phase and maps the result to a 3-bit colour through per-channel bit masks. It sits between the panel scan logic and the LED output shifter and accepts one pixel per clock with a fixed, mode-independent latency.

---
 rtl/tunnel_painter_if.sv | 17 +
 rtl/tunnel_painter.sv | 240 ++++++++++++++++++++++++
 tb/tb_tunnel_painter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tunnel_painter_if.sv
// Pixel stream into the tunnel painter and the colour stream coming back out.
// The scan logic holds the master side; the painter holds the slave side.
interface tunnel_painter_if #(
    parameter int COORD_BITS = 6,
    parameter int FRAME_BITS = 7
);
    logic                  in_valid;
    logic [COORD_BITS-1:0] x;
    logic [COORD_BITS-1:0] y;
    logic [FRAME_BITS-1:0] frame;
    logic [1:0]            mode;
    logic                  out_valid;
    logic [2:0]            rgb;

    modport master (output in_valid, x, y, frame, mode, input out_valid, rgb);
    modport slave  (input in_valid, x, y, frame, mode, output out_valid, rgb);
endinterface

// File: rtl/tunnel_painter.sv
// Pipelined tunnel painter: distance from a centre (Euclidean, diamond or square),
// shifted by a frame-driven phase and mapped to {blue, green, red} via bit masks.
module tunnel_painter #(
    parameter int COORD_BITS  = 6,
    parameter int FRAME_BITS  = 7,
    parameter int CENTER_X    = 32,
    parameter int CENTER_Y    = 32,
    parameter int COLOR_BITS  = 5,
    parameter int SPEED_SHIFT = 2,
    parameter logic [COLOR_BITS-1:0] RED_MASK   = 5'b11111,
    parameter logic [COLOR_BITS-1:0] GREEN_MASK = 5'b00000,
    parameter logic [COLOR_BITS-1:0] BLUE_MASK  = 5'b00011
) (
    input  logic             clk,
    input  logic             resetn,
    tunnel_painter_if.slave  pix
);
    localparam int DW  = COORD_BITS + 1;      // |delta| and root width
    localparam int SW  = COORD_BITS + 2;      // signed difference width
    localparam int SQW = 2 * COORD_BITS + 1;  // one squared delta
    localparam int NW  = 2 * COORD_BITS + 2;  // radicand width
    localparam int RW  = COORD_BITS + 5;      // signed partial remainder
    localparam int NST = COORD_BITS + 1;      // one root bit per stage

    localparam logic [1:0] MODE_IN  = 2'd0;
    localparam logic [1:0] MODE_DIA = 2'd1;
    localparam logic [1:0] MODE_SQ  = 2'd2;
    localparam logic [1:0] MODE_OUT = 2'd3;

    localparam logic [2:0][COLOR_BITS-1:0] MASKS = {BLUE_MASK, GREEN_MASK, RED_MASK};

    // input capture
    logic                  in_valid_reg;
    logic [COORD_BITS-1:0] in_x_reg, in_y_reg;
    logic [FRAME_BITS-1:0] in_frame_reg;
    logic [1:0]            in_mode_reg;

    // stage 1: absolute deltas
    logic signed [SW-1:0]  diff_x, diff_y;
    logic [DW-1:0]         abs_x, abs_y;
    logic                  s1_valid_reg;
    logic [1:0]            s1_mode_reg;
    logic [FRAME_BITS-1:0] s1_frame_reg;
    logic [DW-1:0]         s1_dx_reg, s1_dy_reg;

    // stage 2: squares for the circle, bypass metric for diamond/square
    logic [DW-1:0]         metric_next;
    logic                  s2_valid_reg;
    logic [1:0]            s2_mode_reg;
    logic [FRAME_BITS-1:0] s2_frame_reg;
    logic [SQW-1:0]        s2_a_reg, s2_b_reg;
    logic [DW-1:0]         s2_byp_reg;

    // stage 3: radicand
    logic                  s3_valid_reg;
    logic [1:0]            s3_mode_reg;
    logic [FRAME_BITS-1:0] s3_frame_reg;
    logic [NW-1:0]         s3_n_reg;
    logic [DW-1:0]         s3_byp_reg;

    always_comb begin
        diff_x = SW'(CENTER_X) - $signed({2'b00, in_x_reg});
        diff_y = SW'(CENTER_Y) - $signed({2'b00, in_y_reg});
        abs_x  = diff_x[SW-1] ? DW'(-diff_x) : DW'(diff_x);
        abs_y  = diff_y[SW-1] ? DW'(-diff_y) : DW'(diff_y);
        if (s1_mode_reg == MODE_SQ)
            metric_next = (s1_dx_reg > s1_dy_reg) ? s1_dx_reg : s1_dy_reg;
        else
            metric_next = DW'({1'b0, s1_dx_reg} + {1'b0, s1_dy_reg});
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_valid_reg <= 1'b0;
            in_x_reg     <= '0;
            in_y_reg     <= '0;
            in_frame_reg <= '0;
            in_mode_reg  <= '0;
            s1_valid_reg <= 1'b0;
            s1_mode_reg  <= '0;
            s1_frame_reg <= '0;
            s1_dx_reg    <= '0;
            s1_dy_reg    <= '0;
            s2_valid_reg <= 1'b0;
            s2_mode_reg  <= '0;
            s2_frame_reg <= '0;
            s2_a_reg     <= '0;
            s2_b_reg     <= '0;
            s2_byp_reg   <= '0;
            s3_valid_reg <= 1'b0;
            s3_mode_reg  <= '0;
            s3_frame_reg <= '0;
            s3_n_reg     <= '0;
            s3_byp_reg   <= '0;
        end else begin
            in_valid_reg <= pix.in_valid;
            in_x_reg     <= pix.x;
            in_y_reg     <= pix.y;
            in_frame_reg <= pix.frame;
            in_mode_reg  <= pix.mode;

            s1_valid_reg <= in_valid_reg;
            s1_mode_reg  <= in_mode_reg;
            s1_frame_reg <= in_frame_reg;
            s1_dx_reg    <= abs_x;
            s1_dy_reg    <= abs_y;

            s2_valid_reg <= s1_valid_reg;
            s2_mode_reg  <= s1_mode_reg;
            s2_frame_reg <= s1_frame_reg;
            s2_a_reg     <= {{COORD_BITS{1'b0}}, s1_dx_reg} * {{COORD_BITS{1'b0}}, s1_dx_reg};
            s2_b_reg     <= {{COORD_BITS{1'b0}}, s1_dy_reg} * {{COORD_BITS{1'b0}}, s1_dy_reg};
            s2_byp_reg   <= metric_next;

            s3_valid_reg <= s2_valid_reg;
            s3_mode_reg  <= s2_mode_reg;
            s3_frame_reg <= s2_frame_reg;
            s3_n_reg     <= {1'b0, s2_a_reg} + {1'b0, s2_b_reg};
            s3_byp_reg   <= s2_byp_reg;
        end
    end

    // Non-restoring square root: the radicand is shifted left two bits per stage,
    // the remainder stays signed and the next step adds or subtracts on its sign.
    genvar gi;
    for (gi = 0; gi < NST; gi++) begin : g_root
        logic                  v_in;
        logic [1:0]            m_in;
        logic [FRAME_BITS-1:0] f_in;
        logic [NW-1:0]         n_in;
        logic signed [RW-1:0]  rem_in;
        logic [DW-1:0]         root_in;
        logic [DW-1:0]         byp_in;
        logic signed [RW-1:0]  rem_shift, rem_next;
        logic [DW-1:0]         root_next;

        logic                  valid_reg;
        logic [1:0]            mode_reg;
        logic [FRAME_BITS-1:0] frame_reg;
        logic [NW-1:0]         n_reg;
        logic signed [RW-1:0]  rem_reg;
        logic [DW-1:0]         root_reg;
        logic [DW-1:0]         byp_reg;

        if (gi == 0) begin : g_head
            assign v_in    = s3_valid_reg;
            assign m_in    = s3_mode_reg;
            assign f_in    = s3_frame_reg;
            assign n_in    = s3_n_reg;
            assign rem_in  = '0;
            assign root_in = '0;
            assign byp_in  = s3_byp_reg;
        end else begin : g_link
            assign v_in    = g_root[gi-1].valid_reg;
            assign m_in    = g_root[gi-1].mode_reg;
            assign f_in    = g_root[gi-1].frame_reg;
            assign n_in    = g_root[gi-1].n_reg;
            assign rem_in  = g_root[gi-1].rem_reg;
            assign root_in = g_root[gi-1].root_reg;
            assign byp_in  = g_root[gi-1].byp_reg;
        end

        always_comb begin
            rem_shift = (rem_in <<< 2) + $signed(RW'(n_in[NW-1 -: 2]));
            if (!rem_in[RW-1])
                rem_next = rem_shift - $signed(RW'({root_in, 2'b01}));
            else
                rem_next = rem_shift + $signed(RW'({root_in, 2'b11}));
            root_next = {root_in[DW-2:0], ~rem_next[RW-1]};
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                valid_reg <= 1'b0;
                mode_reg  <= '0;
                frame_reg <= '0;
                n_reg     <= '0;
                rem_reg   <= '0;
                root_reg  <= '0;
                byp_reg   <= '0;
            end else begin
                valid_reg <= v_in;
                mode_reg  <= m_in;
                frame_reg <= f_in;
                n_reg     <= n_in << 2;
                rem_reg   <= rem_next;
                root_reg  <= root_next;
                byp_reg   <= byp_in;
            end
        end
    end

    // final stage: phase and colour masks
    logic                  t_valid;
    logic [1:0]            t_mode;
    logic [FRAME_BITS-1:0] t_frame;
    logic [DW-1:0]         r_sel;
    logic [COLOR_BITS-1:0] offset_c, phase;
    logic [2:0]            rgb_next;
    logic                  out_valid_reg;
    logic [2:0]            rgb_reg;
    logic                  unused_tail;

    assign t_valid     = g_root[NST-1].valid_reg;
    assign t_mode      = g_root[NST-1].mode_reg;
    assign t_frame     = g_root[NST-1].frame_reg;
    assign unused_tail = ^{g_root[NST-1].n_reg, g_root[NST-1].rem_reg};

    always_comb begin
        r_sel    = (t_mode == MODE_DIA || t_mode == MODE_SQ) ? g_root[NST-1].byp_reg
                                                             : g_root[NST-1].root_reg;
        offset_c = COLOR_BITS'(t_frame >> SPEED_SHIFT);
        if (t_mode == MODE_OUT)
            phase = COLOR_BITS'(r_sel) + offset_c;
        else
            phase = COLOR_BITS'(r_sel) - offset_c;
    end

    for (gi = 0; gi < 3; gi++) begin : g_chan
        assign rgb_next[gi] = (MASKS[gi] != '0) && ((phase & MASKS[gi]) == MASKS[gi]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_reg <= 1'b0;
            rgb_reg       <= '0;
        end else begin
            out_valid_reg <= t_valid;
            if (t_valid)
                rgb_reg <= rgb_next;
        end
    end

    assign pix.out_valid = out_valid_reg;
    assign pix.rgb       = rgb_reg;

    // MODE_IN is the default circle case; named for readability of the encoding
    logic unused_mode;
    assign unused_mode = (MODE_IN == 2'd0);
endmodule

// File: tb/tb_tunnel_painter.sv
// Scoreboarded bench for tunnel_painter: default build plus a 32x32 variant,
// expected colours from a floor(sqrt) reference model, latency checked per pixel.
module tb_tunnel_painter;
    localparam int LA = 11;
    localparam int LB = 10;

    typedef struct {
        logic [2:0] rgb;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    logic [2:0] last_a = 3'b000;
    logic [2:0] last_b = 3'b000;

    tunnel_painter_if #(.COORD_BITS(6), .FRAME_BITS(7)) ifa ();
    tunnel_painter_if #(.COORD_BITS(5), .FRAME_BITS(7)) ifb ();

    tunnel_painter dut_a (
        .clk    (clk),
        .resetn (resetn),
        .pix    (ifa)
    );

    tunnel_painter #(
        .COORD_BITS (5),
        .CENTER_X   (16),
        .CENTER_Y   (16),
        .GREEN_MASK (5'b00001)
    ) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .pix    (ifb)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model_rgb(int cb, int cx, int cy, logic [4:0] gm,
                                             int px, int py, int fr, int md);
        int dx, dy, n, r, off, ph;
        logic red, green, blue;
        dx = cx - px;
        if (dx < 0) dx = -dx;
        dy = cy - py;
        if (dy < 0) dy = -dy;
        if (md == 1) r = dx + dy;
        else if (md == 2) r = (dx > dy) ? dx : dy;
        else begin
            n = dx * dx + dy * dy;
            r = 0;
            while ((r + 1) * (r + 1) <= n) r++;
        end
        r   = r % (1 << (cb + 1));
        off = fr >> 2;
        ph  = (md == 3) ? (r + off) : (r - off);
        ph  = ph & 31;
        red   = (ph == 31);
        green = (gm != 5'd0) && ((ph & int'(gm)) == int'(gm));
        blue  = ((ph & 3) == 3);
        return {blue, green, red};
    endfunction

    function automatic logic [2:0] ma(int px, int py, int fr, int md);
        return model_rgb(6, 32, 32, 5'b00000, px, py, fr, md);
    endfunction

    function automatic logic [2:0] mb(int px, int py, int fr, int md);
        return model_rgb(5, 16, 16, 5'b00001, px, py, fr, md);
    endfunction

    task automatic check_dut(input string tag, input logic ov, input logic [2:0] rg,
                             input bit have, input exp_t head,
                             inout logic [2:0] last, output bit popped);
        bit want_v;
        want_v = have && (head.due == cyc);
        popped = want_v;
        checks++;
        assert (ov === want_v) else begin
            errors++;
            $error("FAIL %s_valid cyc %0d observed %b expected %b", tag, cyc, ov, want_v);
        end
        if (want_v) begin
            checks++;
            assert (rg === head.rgb) else begin
                errors++;
                $error("FAIL %s_rgb cyc %0d observed %b expected %b", tag, cyc, rg, head.rgb);
            end
            $display("%s out cyc %0d rgb %b expected %b", tag, cyc, rg, head.rgb);
            last = head.rgb;
        end else if (ov !== 1'b1) begin
            checks++;
            assert (rg === last) else begin
                errors++;
                $error("FAIL %s_hold cyc %0d observed %b expected %b", tag, cyc, rg, last);
            end
        end
    endtask

    task automatic tick();
        exp_t dflt;
        bit   pa, pb;
        dflt = '{rgb: 3'b000, due: -1};
        @(posedge clk);
        cyc++;
        #1;
        check_dut("a", ifa.out_valid, ifa.rgb, sb_a.size() > 0,
                  (sb_a.size() > 0) ? sb_a[0] : dflt, last_a, pa);
        if (pa) void'(sb_a.pop_front());
        check_dut("b", ifb.out_valid, ifb.rgb, sb_b.size() > 0,
                  (sb_b.size() > 0) ? sb_b[0] : dflt, last_b, pb);
        if (pb) void'(sb_b.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_a(input int px, input int py, input int fr, input int md,
                          input logic [2:0] e);
        ifa.in_valid = 1'b1;
        ifa.x        = 6'(px);
        ifa.y        = 6'(py);
        ifa.frame    = 7'(fr);
        ifa.mode     = 2'(md);
        sb_a.push_back('{rgb: e, due: cyc + 1 + LA});
        tick();
        ifa.in_valid = 1'b0;
    endtask

    task automatic send_b(input int px, input int py, input int fr, input int md,
                          input logic [2:0] e);
        ifb.in_valid = 1'b1;
        ifb.x        = 5'(px);
        ifb.y        = 5'(py);
        ifb.frame    = 7'(fr);
        ifb.mode     = 2'(md);
        sb_b.push_back('{rgb: e, due: cyc + 1 + LB});
        tick();
        ifb.in_valid = 1'b0;
    endtask

    initial begin
        int px, py, fr, md;
        ifa.in_valid = 1'b0; ifa.x = '0; ifa.y = '0; ifa.frame = '0; ifa.mode = '0;
        ifb.in_valid = 1'b0; ifb.x = '0; ifb.y = '0; ifb.frame = '0; ifb.mode = '0;

        // reset state: outputs quiet and zero
        resetn = 1'b0;
        idle(3);
        resetn = 1'b1;
        idle(2);

        // directed pixels with hand-derived colours
        send_a(1, 32, 0, 0, 3'b101);     // r=31 phase 31
        send_a(1, 32, 4, 0, 3'b000);     // phase 30
        send_a(29, 28, 24, 0, 3'b101);   // r=5, 5-6 wraps to 31
        send_a(29, 28, 8, 0, 3'b100);    // phase 3
        send_a(0, 0, 56, 0, 3'b101);     // r=45, 45-14 = 31
        send_a(32, 32, 4, 0, 3'b101);    // r=0, 0-1 wraps to 31
        send_a(29, 28, 32, 1, 3'b101);   // diamond r=7, 7-8 -> 31
        send_a(29, 28, 20, 2, 3'b101);   // square r=4, 4-5 -> 31
        send_a(29, 28, 4, 3, 3'b000);    // outward phase 6
        send_a(29, 28, 104, 3, 3'b101);  // 5+26 = 31
        send_a(29, 28, 120, 3, 3'b100);  // 5+30 wraps to 3
        idle(LA + 2);

        // isolated pixel: exact latency with idle pipeline around it
        send_a(29, 28, 24, 0, 3'b101);
        idle(LA + 2);

        // full-panel root sweep, mode 0
        for (int i = 0; i < 4096; i++) begin
            fr = (i * 7) % 128;
            send_a(i % 64, i / 64, fr, 0, ma(i % 64, i / 64, fr, 0));
        end
        idle(LA + 2);

        // 20 pixels, 3-cycle gap, 5 pixels, mode changing every pixel
        for (int i = 0; i < 25; i++) begin
            if (i == 20) idle(3);
            px = $urandom_range(0, 63);
            py = $urandom_range(0, 63);
            fr = $urandom_range(0, 127);
            md = i % 4;
            send_a(px, py, fr, md, ma(px, py, fr, md));
        end
        idle(LA + 2);

        // reset while the pipeline is full and the first pixel is on the output
        for (int i = 0; i < 12; i++) send_a(32, 32, 4, 0, 3'b101);
        resetn = 1'b0;
        #1;
        checks++;
        assert (ifa.out_valid === 1'b0) else begin
            errors++;
            $error("FAIL async_valid observed %b expected 0", ifa.out_valid);
        end
        checks++;
        assert (ifa.rgb === 3'b000) else begin
            errors++;
            $error("FAIL async_rgb observed %b expected 000", ifa.rgb);
        end
        sb_a.delete();
        last_a = 3'b000;
        tick();
        resetn = 1'b1;
        idle(2);
        send_a(0, 0, 56, 0, 3'b101);
        send_a(1, 32, 0, 0, 3'b101);
        idle(LA + 4);

        // variant build: 32x32 panel, centre (16,16), green on phase bit 0
        for (int i = 0; i < 1024; i++) begin
            fr = (i * 5) % 128;
            send_b(i % 32, i / 32, fr, 0, mb(i % 32, i / 32, fr, 0));
        end
        for (int i = 0; i < 64; i++) begin
            px = $urandom_range(0, 31);
            py = $urandom_range(0, 31);
            fr = $urandom_range(0, 127);
            md = $urandom_range(0, 3);
            send_b(px, py, fr, md, mb(px, py, fr, md));
        end
        idle(LB + 2);

        checks++;
        assert (sb_a.size() + sb_b.size() == 0) else begin
            errors++;
            $error("FAIL drain observed %0d expected 0", sb_a.size() + sb_b.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
